ibex_rf_wb_arbiter: RTL and testbench



---
 rtl/ibex_pkg.sv | 17 +
 rtl/ibex_rf_pending_fifo.sv | 106 ++++++++++
 rtl/ibex_rf_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared definitions for the register-file write-back path.
//   addr_width() : architectural register address width (4 for RV32E, else 5)
//   rf_wr_t      : one register-file write (address + 32-bit data)
package ibex_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [31:0]         data;
    } rf_wr_t;

    function automatic int unsigned addr_width(input bit rv32e);
        return rv32e ? 4 : 5;
    endfunction

endpackage

// File: rtl/ibex_rf_pending_fifo.sv
// Pending-load destination FIFO.
// Holds the destination registers of issued loads in issue order. It has
// parallel compare ports for the EX write address (WAW) and the two ID read
// addresses.
//   clk_i, rst_i          : clock, synchronous active-high reset (empties FIFO)
//   push_i / push_addr_i  : record a new load destination
//   pop_i                 : retire the head entry (caller guarantees non-empty)
//   head_o                : destination of the oldest outstanding load
//   empty_o / full_o      : occupancy flags
//   waw_addr_i -> waw_o   : address matches any valid nonzero entry
//   a/b_addr_i -> a/b_match_o : same, but the entry popped this cycle is excluded
module ibex_rf_pending_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [RegAddrW-1:0] push_addr_i,
    input  logic                pop_i,
    output logic [RegAddrW-1:0] head_o,
    output logic                empty_o,
    output logic                full_o,
    input  logic [RegAddrW-1:0] waw_addr_i,
    input  logic [RegAddrW-1:0] a_addr_i,
    input  logic [RegAddrW-1:0] b_addr_i,
    output logic                waw_o,
    output logic                a_match_o,
    output logic                b_match_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [RegAddrW-1:0] AddrMask = RegAddrW'((1 << AddrWidth) - 1);

    logic [RegAddrW-1:0] r_addr [Depth];
    logic [PtrW-1:0]     r_rd_ptr;
    logic [PtrW-1:0]     r_wr_ptr;
    logic [CntW-1:0]     r_count;

    logic [Depth-1:0] w_valid;
    logic [Depth-1:0] w_hit_waw;
    logic [Depth-1:0] w_hit_a;
    logic [Depth-1:0] w_hit_b;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        int unsigned rd;
        int unsigned off;
        logic        live;
        logic        nz;
        w_valid   = '0;
        w_hit_waw = '0;
        w_hit_a   = '0;
        w_hit_b   = '0;
        rd        = 32'(r_rd_ptr);
        off       = 0;
        live      = 1'b0;
        nz        = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            off        = (i >= rd) ? (i - rd) : (i + Depth - rd);
            w_valid[i] = off < 32'(r_count);
            nz         = |r_addr[i];
            // The entry leaving this cycle has its data forwarded, so reads need not wait on it.
            live       = w_valid[i] && !(pop_i && (i == rd));
            w_hit_waw[i] = w_valid[i] && nz && (r_addr[i] == (waw_addr_i & AddrMask));
            w_hit_a[i]   = live && nz && (r_addr[i] == (a_addr_i & AddrMask));
            w_hit_b[i]   = live && nz && (r_addr[i] == (b_addr_i & AddrMask));
        end
    end

    assign waw_o     = |w_hit_waw;
    assign a_match_o = |w_hit_a;
    assign b_match_o = |w_hit_b;
    assign head_o    = r_addr[r_rd_ptr];
    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CntW'(Depth));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_addr[r_wr_ptr] <= push_addr_i & AddrMask;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (pop_i) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (push_i && !pop_i) begin
                r_count <= r_count + CntW'(1);
            end else if (!push_i && pop_i) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter and read-bypass stage in front of the single-write-port
// latch register file.
//   EX write port     : ex_we_i/ex_waddr_i/ex_wdata_i, ex_ready_o
//   LSU issue/return  : lsu_req_i/lsu_req_waddr_i/lsu_req_ready_o,
//                       lsu_rvalid_i/lsu_rdata_i, lsu_err_o (spurious return)
//   ID operand reads  : raddr/rvalid/rf_rdata per port a,b -> rdata_a/b_o, stall_o
//   RF write port     : rf_we_o/rf_waddr_o/rf_wdata_o
// Load returns have priority and cannot be stalled. An EX write that collides
// with a load return is parked in a one-entry skid buffer.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LsuDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_req_waddr_i,
    output logic                 lsu_req_ready_o,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic                 rvalid_a_i,
    input  logic                 rvalid_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 stall_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 lsu_err_o
);

    localparam int unsigned AddrWidth = addr_width(RV32E);
    localparam logic [4:0]  AddrMask  = 5'((1 << AddrWidth) - 1);

    logic                 buf_valid_q;
    logic [4:0]           buf_addr_q;
    logic [DataWidth-1:0] buf_data_q;
    logic                 r_lsu_err;

    logic [4:0]           w_fifo_head;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_waw;
    logic                 w_match_a;
    logic                 w_match_b;
    logic                 w_lsu_wr;
    logic                 w_ex_acc;
    logic                 w_push;
    logic                 w_port_busy;
    logic [4:0]           w_waddr;
    logic [DataWidth-1:0] w_wdata;

    assign w_lsu_wr        = lsu_rvalid_i && !w_fifo_empty;
    assign ex_ready_o      = !rst_i && !buf_valid_q && !w_waw;
    assign w_ex_acc        = ex_we_i && ex_ready_o;
    assign lsu_req_ready_o = !rst_i && (!w_fifo_full || (lsu_rvalid_i && !w_fifo_empty));
    assign w_push          = lsu_req_i && lsu_req_ready_o;

    ibex_rf_pending_fifo #(
        .Depth     (LsuDepth),
        .AddrWidth (AddrWidth)
    ) u_pending_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_addr_i (lsu_req_waddr_i),
        .pop_i       (w_lsu_wr),
        .head_o      (w_fifo_head),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full),
        .waw_addr_i  (ex_waddr_i),
        .a_addr_i    (raddr_a_i),
        .b_addr_i    (raddr_b_i),
        .waw_o       (w_waw),
        .a_match_o   (w_match_a),
        .b_match_o   (w_match_b)
    );

    // Write-port priority: load return, then skid buffer, then direct EX write.
    always_comb begin
        w_port_busy = 1'b1;
        w_waddr     = ex_waddr_i & AddrMask;
        w_wdata     = ex_wdata_i;
        if (w_lsu_wr) begin
            w_waddr = w_fifo_head;
            w_wdata = lsu_rdata_i;
        end else if (buf_valid_q) begin
            w_waddr = buf_addr_q;
            w_wdata = buf_data_q;
        end else if (!w_ex_acc) begin
            w_port_busy = 1'b0;
        end
    end

    // x0 writes still use their arbitration slot but never reach the file.
    assign rf_we_o    = !rst_i && w_port_busy && (|w_waddr);
    assign rf_waddr_o = w_waddr;
    assign rf_wdata_o = w_wdata;

    // The buffer is always younger than the current write, so it wins on a match.
    function automatic logic [DataWidth-1:0] bypass(
        input logic [4:0]           raddr,
        input logic [DataWidth-1:0] rf_rdata,
        input logic                 bv,
        input logic [4:0]           ba,
        input logic [DataWidth-1:0] bd,
        input logic                 we,
        input logic [4:0]           wa,
        input logic [DataWidth-1:0] wd
    );
        logic [4:0] a;
        a = raddr & AddrMask;
        if (a == '0)            return '0;
        if (bv && (ba == a))    return bd;
        if (we && (wa == a))    return wd;
        return rf_rdata;
    endfunction

    assign rdata_a_o = bypass(raddr_a_i, rf_rdata_a_i, buf_valid_q, buf_addr_q, buf_data_q,
                              rf_we_o, w_waddr, w_wdata);
    assign rdata_b_o = bypass(raddr_b_i, rf_rdata_b_i, buf_valid_q, buf_addr_q, buf_data_q,
                              rf_we_o, w_waddr, w_wdata);

    assign stall_o   = (rvalid_a_i && w_match_a) || (rvalid_b_i && w_match_b);
    assign lsu_err_o = r_lsu_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            r_lsu_err   <= 1'b0;
        end else begin
            r_lsu_err <= lsu_rvalid_i && w_fifo_empty;
            if (w_ex_acc && w_lsu_wr) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= ex_waddr_i & AddrMask;
                buf_data_q  <= ex_wdata_i;
            end else if (buf_valid_q && !w_lsu_wr) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter with default parameters.
// Expected RF writes are queued as stimulus is driven and retired by a
// monitor whenever the DUT asserts rf_we_o.
module tb_ibex_rf_wb_arbiter;
    import ibex_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        lsu_req_i;
    logic [4:0]  lsu_req_waddr_i;
    logic        lsu_req_ready_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic        rvalid_a_i;
    logic        rvalid_b_i;
    logic [31:0] rf_rdata_a_i;
    logic [31:0] rf_rdata_b_i;
    logic [31:0] rdata_a_o;
    logic [31:0] rdata_b_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        lsu_err_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    rf_wr_t      exp_q[$];
    logic [31:0] rf_model [32];

    ibex_rf_wb_arbiter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ex_we_i         (ex_we_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .ex_ready_o      (ex_ready_o),
        .lsu_req_i       (lsu_req_i),
        .lsu_req_waddr_i (lsu_req_waddr_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .lsu_rvalid_i    (lsu_rvalid_i),
        .lsu_rdata_i     (lsu_rdata_i),
        .raddr_a_i       (raddr_a_i),
        .raddr_b_i       (raddr_b_i),
        .rvalid_a_i      (rvalid_a_i),
        .rvalid_b_i      (rvalid_b_i),
        .rf_rdata_a_i    (rf_rdata_a_i),
        .rf_rdata_b_i    (rf_rdata_b_i),
        .rdata_a_o       (rdata_a_o),
        .rdata_b_o       (rdata_b_o),
        .stall_o         (stall_o),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .lsu_err_o       (lsu_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural latch file: writes become visible to reads the cycle after.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf_model[i] <= 32'hA000_0000 + 32'(i);
        end else if (rf_we_o) begin
            rf_model[rf_waddr_o] <= rf_wdata_o;
        end
    end
    assign rf_rdata_a_i = rf_model[raddr_a_i];
    assign rf_rdata_b_i = rf_model[raddr_b_i];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle while inputs are stable.
    always begin
        rf_wr_t e;
        @(negedge clk_i);
        #2;
        if (rf_we_o) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'(rf_we_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(rf_waddr_o), 32'(e.addr));
                check_eq("wr_data", rf_wdata_o, e.data);
            end
        end
    end

    task automatic idle();
        ex_we_i         = 1'b0;
        ex_waddr_i      = '0;
        ex_wdata_i      = '0;
        lsu_req_i       = 1'b0;
        lsu_req_waddr_i = '0;
        lsu_rvalid_i    = 1'b0;
        lsu_rdata_i     = '0;
        raddr_a_i       = '0;
        raddr_b_i       = '0;
        rvalid_a_i      = 1'b0;
        rvalid_b_i      = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        rf_wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        check_eq("rst_ex_ready", 32'(ex_ready_o), 0);
        check_eq("rst_req_ready", 32'(lsu_req_ready_o), 0);
        check_eq("rst_we", 32'(rf_we_o), 0);

        @(negedge clk_i); rst_i = 1'b0; #1;
        check_eq("post_rst_ex_ready", 32'(ex_ready_o), 1);
        check_eq("post_rst_req_ready", 32'(lsu_req_ready_o), 1);
        check_eq("post_rst_stall", 32'(stall_o), 0);
        check_eq("post_rst_err", 32'(lsu_err_o), 0);

        // EX write with same-cycle read bypass.
        @(negedge clk_i);
        ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEAD_BEEF;
        raddr_a_i = 5; rvalid_a_i = 1; raddr_b_i = 6; rvalid_b_i = 1;
        expect_wr(5, 32'hDEAD_BEEF);
        #1;
        check_eq("ex_we", 32'(rf_we_o), 1);
        check_eq("ex_byp_a", rdata_a_o, 32'hDEAD_BEEF);
        check_eq("ex_raw_b", rdata_b_o, 32'hA000_0006);
        @(negedge clk_i); ex_we_i = 0; #1;
        check_eq("ex_rf_a", rdata_a_o, 32'hDEAD_BEEF);

        // Load to x7, operand stall until return.
        @(negedge clk_i); idle(); lsu_req_i = 1; lsu_req_waddr_i = 7; #1;
        check_eq("ld7_req_ready", 32'(lsu_req_ready_o), 1);
        @(negedge clk_i); lsu_req_i = 0; raddr_a_i = 7; rvalid_a_i = 0; #1;
        check_eq("ld7_unused_stall", 32'(stall_o), 0);
        @(negedge clk_i); rvalid_a_i = 1; #1;
        check_eq("ld7_stall", 32'(stall_o), 1);
        @(negedge clk_i); lsu_rvalid_i = 1; lsu_rdata_i = 32'h1234; expect_wr(7, 32'h1234); #1;
        check_eq("ld7_ret_stall", 32'(stall_o), 0);
        check_eq("ld7_ret_byp", rdata_a_o, 32'h1234);
        check_eq("ld7_ret_addr", 32'(rf_waddr_o), 7);
        @(negedge clk_i); lsu_rvalid_i = 0; #1;
        check_eq("ld7_after_stall", 32'(stall_o), 0);
        check_eq("ld7_after_rd", rdata_a_o, 32'h1234);

        // LSU return collides with EX write to x3.
        @(negedge clk_i); idle(); lsu_req_i = 1; lsu_req_waddr_i = 8;
        @(negedge clk_i);
        lsu_req_i = 0; lsu_rvalid_i = 1; lsu_rdata_i = 32'h77;
        ex_we_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'h55;
        raddr_a_i = 3; rvalid_a_i = 1;
        expect_wr(8, 32'h77);
        expect_wr(3, 32'h55);
        #1;
        check_eq("col_ex_ready", 32'(ex_ready_o), 1);
        check_eq("col_waddr", 32'(rf_waddr_o), 8);
        check_eq("col_rd_old", rdata_a_o, 32'hA000_0003);
        @(negedge clk_i); lsu_rvalid_i = 0; ex_we_i = 0; #1;
        check_eq("buf_ex_ready", 32'(ex_ready_o), 0);
        check_eq("buf_drain_addr", 32'(rf_waddr_o), 3);
        check_eq("buf_byp", rdata_a_o, 32'h55);
        @(negedge clk_i); #1;
        check_eq("buf_done_ready", 32'(ex_ready_o), 1);
        check_eq("buf_done_rd", rdata_a_o, 32'h55);

        // Two outstanding loads, third accepted with a return, order across wrap.
        @(negedge clk_i); idle(); lsu_req_i = 1; lsu_req_waddr_i = 10; #1;
        check_eq("fifo_rdy0", 32'(lsu_req_ready_o), 1);
        @(negedge clk_i); lsu_req_waddr_i = 11; #1;
        check_eq("fifo_rdy1", 32'(lsu_req_ready_o), 1);
        @(negedge clk_i); lsu_req_waddr_i = 12; #1;
        check_eq("fifo_full", 32'(lsu_req_ready_o), 0);
        @(negedge clk_i); lsu_rvalid_i = 1; lsu_rdata_i = 32'hA10; expect_wr(10, 32'hA10); #1;
        check_eq("fifo_push_pop_rdy", 32'(lsu_req_ready_o), 1);
        check_eq("fifo_head10", 32'(rf_waddr_o), 10);
        @(negedge clk_i);
        lsu_req_i = 0; lsu_rdata_i = 32'hB11; raddr_b_i = 12; rvalid_b_i = 1;
        expect_wr(11, 32'hB11);
        #1;
        check_eq("fifo_head11", 32'(rf_waddr_o), 11);
        check_eq("fifo_stall12", 32'(stall_o), 1);
        @(negedge clk_i); lsu_rdata_i = 32'hC12; expect_wr(12, 32'hC12); #1;
        check_eq("fifo_head12", 32'(rf_waddr_o), 12);
        check_eq("fifo_nostall12", 32'(stall_o), 0);
        check_eq("fifo_byp12", rdata_b_o, 32'hC12);

        // WAW block on x9, then x0 behaviour.
        @(negedge clk_i); idle(); lsu_req_i = 1; lsu_req_waddr_i = 9;
        @(negedge clk_i); lsu_req_i = 0; ex_we_i = 1; ex_waddr_i = 9; ex_wdata_i = 32'h99; #1;
        check_eq("waw_ready", 32'(ex_ready_o), 0);
        check_eq("waw_no_we", 32'(rf_we_o), 0);
        @(negedge clk_i); lsu_rvalid_i = 1; lsu_rdata_i = 32'h909; expect_wr(9, 32'h909); #1;
        check_eq("waw_ret_ready", 32'(ex_ready_o), 0);
        check_eq("waw_ret_addr", 32'(rf_waddr_o), 9);
        @(negedge clk_i); lsu_rvalid_i = 0; raddr_a_i = 9; rvalid_a_i = 1; expect_wr(9, 32'h99); #1;
        check_eq("waw_clear_ready", 32'(ex_ready_o), 1);
        check_eq("waw_clear_byp", rdata_a_o, 32'h99);
        @(negedge clk_i); ex_waddr_i = 0; ex_wdata_i = 32'hFFFF; raddr_a_i = 0; #1;
        check_eq("x0_ready", 32'(ex_ready_o), 1);
        check_eq("x0_we", 32'(rf_we_o), 0);
        check_eq("x0_rd", rdata_a_o, 0);
        @(negedge clk_i); ex_we_i = 0; lsu_req_i = 1; lsu_req_waddr_i = 0;
        @(negedge clk_i); lsu_req_i = 0; #1;
        check_eq("ld_x0_stall", 32'(stall_o), 0);
        check_eq("ld_x0_ex_ready", 32'(ex_ready_o), 1);
        @(negedge clk_i); lsu_rvalid_i = 1; lsu_rdata_i = 32'h5; #1;
        check_eq("ld_x0_we", 32'(rf_we_o), 0);
        @(negedge clk_i); idle(); #1;
        check_eq("ld_x0_err", 32'(lsu_err_o), 0);

        // Spurious return with an empty FIFO.
        @(negedge clk_i); lsu_rvalid_i = 1; lsu_rdata_i = 32'hBAD0; #1;
        check_eq("spur_we", 32'(rf_we_o), 0);
        @(negedge clk_i); idle(); #1;
        check_eq("spur_err", 32'(lsu_err_o), 1);
        @(negedge clk_i); #1;
        check_eq("spur_err_pulse", 32'(lsu_err_o), 0);

        // Reset with loads pending; a late return must flag an error.
        @(negedge clk_i); lsu_req_i = 1; lsu_req_waddr_i = 13;
        @(negedge clk_i); lsu_req_waddr_i = 14;
        @(negedge clk_i); idle(); rst_i = 1; #1;
        check_eq("mid_rst_ex_ready", 32'(ex_ready_o), 0);
        check_eq("mid_rst_req_ready", 32'(lsu_req_ready_o), 0);
        check_eq("mid_rst_we", 32'(rf_we_o), 0);
        @(negedge clk_i); rst_i = 0; raddr_a_i = 13; rvalid_a_i = 1; #1;
        check_eq("mid_rst_stall", 32'(stall_o), 0);
        check_eq("mid_rst_req_rdy1", 32'(lsu_req_ready_o), 1);
        check_eq("mid_rst_ex_rdy1", 32'(ex_ready_o), 1);
        check_eq("mid_rst_err", 32'(lsu_err_o), 0);
        @(negedge clk_i); idle(); lsu_rvalid_i = 1; lsu_rdata_i = 32'hBAD1; #1;
        check_eq("late_ret_we", 32'(rf_we_o), 0);
        @(negedge clk_i); idle(); #1;
        check_eq("late_ret_err", 32'(lsu_err_o), 1);

        @(negedge clk_i); #3;
        check_eq("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
